// File: rtl/bo_pkg.sv
// bo_pkg: shared encodings for the bo_datapath operative block.
//   - Operand A / operand B mux select encodings (m0 / m1).
//   - ALU op codes (m2).
//   - Default data width.
// Optional feature macro used by files importing this package: BO_OVF_DETECT_EN.
package bo_pkg;

  localparam int unsigned BO_W = 8;

  typedef enum logic [1:0] {
    SEL_A_ZERO = 2'b00,
    SEL_A_X    = 2'b01,
    SEL_A_S    = 2'b10,
    SEL_A_H    = 2'b11
  } sel_a_e;

  typedef enum logic [1:0] {
    SEL_B_X    = 2'b00,
    SEL_B_ZERO = 2'b01,
    SEL_B_H    = 2'b10,
    SEL_B_S    = 2'b11
  } sel_b_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_SHL = 2'b11
  } op_e;

endpackage

// File: rtl/bo_datapath_if.sv
// bo_datapath_if: bundle between the control FSM (master) and the datapath (slave).
//   master drives : x_in, m0, m1, m2, lx, ls, lh, h
//   slave drives  : y_out, done (and ovf when BO_OVF_DETECT_EN is defined)
// Protocol: there is no valid/ready pair. Control words (m0/m1/m2/lx/ls/lh) are
// consumed on every rising clk edge they are present; a 0->1 change of h is the
// "result request", answered one edge later by y_out updating together with a
// single-cycle done pulse. done carries no backpressure and is never held.
interface bo_datapath_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] x_in;
  logic [1:0]   m0;
  logic [1:0]   m1;
  logic [1:0]   m2;
  logic         lx;
  logic         ls;
  logic         lh;
  logic         h;
  logic [W-1:0] y_out;
  logic         done;
`ifdef BO_OVF_DETECT_EN
  logic         ovf;
`endif

  modport master (
    output x_in, m0, m1, m2, lx, ls, lh, h,
`ifdef BO_OVF_DETECT_EN
    input  ovf,
`endif
    input  y_out, done
  );

  modport slave (
    input  x_in, m0, m1, m2, lx, ls, lh, h,
`ifdef BO_OVF_DETECT_EN
    output ovf,
`endif
    output y_out, done
  );
endinterface

// File: rtl/bo_alu.sv
// bo_alu: combinational ALU, all results modulo 2^W.
//   a_i, b_i  : operands
//   op_i      : OP_ADD / OP_SUB / OP_MUL / OP_SHL (SHL ignores b_i)
//   r_o       : low W bits of the result
//   ovf_raw_o : carry out (add), borrow (sub), non-zero high half (mul),
//               discarded MSB (shl); consumed only when BO_OVF_DETECT_EN is set
module bo_alu
  import bo_pkg::*;
#(
  parameter int unsigned W = BO_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  op_e          op_i,
  output logic [W-1:0] r_o,
  output logic         ovf_raw_o
);

  logic [W:0]     sum_w;
  logic [W:0]     diff_w;
  logic [2*W-1:0] prod_w;

  // One extra bit on add/sub captures carry/borrow.
  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_w = {1'b0, a_i} - {1'b0, b_i};
  assign prod_w = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

  always_comb begin
    r_o       = '0;
    ovf_raw_o = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        r_o       = sum_w[W-1:0];
        ovf_raw_o = sum_w[W];
      end
      OP_SUB: begin
        r_o       = diff_w[W-1:0];
        ovf_raw_o = diff_w[W];
      end
      OP_MUL: begin
        r_o       = prod_w[W-1:0];
        ovf_raw_o = |prod_w[2*W-1:W];
      end
      OP_SHL: begin
        r_o       = {a_i[W-2:0], 1'b0};
        ovf_raw_o = a_i[W-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bo_datapath.sv
// bo_datapath: operative block driven by the control FSM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : bo_datapath_if slave (x_in, m0, m1, m2, lx, ls, lh, h in;
//              y_out, done out; ovf out when BO_OVF_DETECT_EN is defined)
// Holds X, S and H, computes R = alu(muxA, muxB, m2) from current register
// contents, and publishes S on y_out with a done pulse on each 0->1 of h.
// Optional feature: define BO_OVF_DETECT_EN for the sticky ovf flag.
module bo_datapath
  import bo_pkg::*;
#(
  parameter int unsigned W = BO_W
) (
  input  logic          clk,
  input  logic          rst,
  bo_datapath_if.slave  bus
);

  logic [W-1:0] x_q, x_d;
  logic [W-1:0] s_q, s_d;
  logic [W-1:0] hreg_q, hreg_d;
  logic [W-1:0] y_q, y_d;
  logic         h_q;
  logic         done_q, done_d;
  logic         h_rise;
  logic [W-1:0] op_a, op_b, alu_r;
  logic         alu_ovf;

  always_comb begin
    op_a = '0;
    unique case (sel_a_e'(bus.m0))
      SEL_A_ZERO: op_a = '0;
      SEL_A_X:    op_a = x_q;
      SEL_A_S:    op_a = s_q;
      SEL_A_H:    op_a = hreg_q;
      default:    op_a = '0;
    endcase
  end

  always_comb begin
    op_b = '0;
    unique case (sel_b_e'(bus.m1))
      SEL_B_X:    op_b = x_q;
      SEL_B_ZERO: op_b = '0;
      SEL_B_H:    op_b = hreg_q;
      SEL_B_S:    op_b = s_q;
      default:    op_b = '0;
    endcase
  end

  bo_alu #(.W(W)) u_alu (
    .a_i       (op_a),
    .b_i       (op_b),
    .op_i      (op_e'(bus.m2)),
    .r_o       (alu_r),
    .ovf_raw_o (alu_ovf)
  );

  // R is built from the pre-edge X, so lx on the same edge as ls/lh sees old X.
  always_comb begin
    x_d    = bus.lx ? bus.x_in : x_q;
    s_d    = bus.ls ? alu_r : s_q;
    hreg_d = bus.lh ? alu_r : hreg_q;
    h_rise = bus.h & ~h_q;
    y_d    = h_rise ? s_q : y_q;
    done_d = h_rise;
  end

  // h_q resets to 1 so leaving reset with h=1 is not seen as a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      s_q    <= '0;
      hreg_q <= '0;
      y_q    <= '0;
      h_q    <= 1'b1;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      s_q    <= s_d;
      hreg_q <= hreg_d;
      y_q    <= y_d;
      h_q    <= bus.h;
      done_q <= done_d;
    end
  end

  assign bus.y_out = y_q;
  assign bus.done  = done_q;

`ifdef BO_OVF_DETECT_EN
  logic ovf_q;

  // Sticky: a new overflowing load wins over the clear from lx.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((bus.ls || bus.lh) && alu_ovf) begin
      ovf_q <= 1'b1;
    end else if (bus.lx) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic ovf_raw_unused;
  assign ovf_raw_unused = alu_ovf;
`endif

endmodule
